// File: rtl/axi_transmit.sv
// axi_transmit: serializes one DATA_WIDTH word per handshake into BUS_WIDTH
// packets, least-significant chunk first, with valid/ready flow control.
// Memory IDs can optionally be turned into absolute bus addresses at accept.

`ifndef ABS_ID_CEILING
`define ABS_ID_CEILING 1000
`endif
`ifndef ID2ADDR
`define ID2ADDR(id) (64'h1000 + (64'(id) << 3))
`endif

module axi_transmit #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [BUS_WIDTH-1:0]  packet,
  output logic                  valid_pack,
  input  logic                  pack_ready,
  output logic                  done
);

  // state | meaning
  // IDLE  | no word in flight, ready for a new word, packet bus driven to zero
  // SEND  | presenting shift_reg low chunk as a valid packet

  localparam int RAW_PACKS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int NUM_PACKS = (RAW_PACKS < 1) ? 1 : RAW_PACKS;
  localparam int SR_WIDTH  = NUM_PACKS * BUS_WIDTH;
  localparam int IDX_WIDTH = $clog2(NUM_PACKS) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state;
  logic [SR_WIDTH-1:0]    shift_reg;
  logic [IDX_WIDTH-1:0]   pack_idx;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  addr_word;
  logic [63:0]            id_clamped;
  logic                   pack_fire;
  logic                   last_pack;
  logic                   accept;

  // Word to load: either the raw data or its clamped ID-to-address translation.
  always_comb begin
    id_clamped = 64'(data_in);
    if (id_clamped > 64'(`ABS_ID_CEILING)) begin
      id_clamped = 64'(`ABS_ID_CEILING);
    end
    addr_word = DATA_WIDTH'(`ID2ADDR(id_clamped));
    word      = is_addr ? addr_word : data_in;
  end

  // A new word may overlap the final packet handshake, so ready_out looks at
  // pack_ready combinationally to keep back-to-back words gap-free.
  assign pack_fire = (state == SEND) && pack_ready;
  assign last_pack = (pack_idx == IDX_WIDTH'(NUM_PACKS - 1));
  assign ready_out = (state == IDLE) || (pack_fire && last_pack);
  assign accept    = valid_in && ready_out;

  // Shift register is zero once every chunk has gone out, so the packet bus
  // reads zero while idle without extra muxing.
  assign packet = shift_reg[BUS_WIDTH-1:0];

  // Transmit FSM: load on accept, shift on each packet handshake, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_pack <= 1'b0;
      shift_reg  <= '0;
      pack_idx   <= '0;
      done       <= 1'b0;
    end else begin
      done <= pack_fire && last_pack;
      if (accept) begin
        shift_reg  <= SR_WIDTH'(word);
        pack_idx   <= '0;
        state      <= SEND;
        valid_pack <= 1'b1;
      end else if (pack_fire) begin
        shift_reg <= shift_reg >> BUS_WIDTH;
        if (last_pack) begin
          state      <= IDLE;
          valid_pack <= 1'b0;
          pack_idx   <= '0;
        end else begin
          pack_idx <= pack_idx + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_transmit.sv
// Bench for axi_transmit: three width configurations run against a
// queue-based packet model, plus directed literal checks and a loopback
// reassembly of every transmitted word.

`ifndef ABS_ID_CEILING
`define ABS_ID_CEILING 1000
`endif
`ifndef ID2ADDR
`define ID2ADDR(id) (64'h1000 + (64'(id) << 3))
`endif

module tb_axi_transmit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        rst_v    [3];
  logic        isaddr_v [3];
  logic        vin_v    [3];
  logic        prdy_v   [3];
  logic [63:0] din_v    [3];
  logic        rdy_v    [3];
  logic        vp_v     [3];
  logic        done_v   [3];
  logic [63:0] pkt_v    [3];

  function automatic int bw_of(int c);
    case (c)
      0:       return 32;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int dw_of(int c);
    case (c)
      0:       return 16;
      1:       return 48;
      default: return 20;
    endcase
  endfunction

  task automatic chk(string name, int c, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cfg%0d t=%0t: got %h, expected %h", name, c, $time, act, exp);
    end
  endtask

  for (genvar c = 0; c < 3; c++) begin : g
    localparam int BW = bw_of(c);
    localparam int DW = dw_of(c);
    localparam int NP = (DW + BW - 1) / BW;
    localparam logic [63:0] BMASK = (64'd1 << BW) - 64'd1;
    localparam logic [63:0] DMASK = (64'd1 << DW) - 64'd1;

    logic [BW-1:0] packet;
    logic [DW-1:0] din;

    assign din      = din_v[c][DW-1:0];
    assign pkt_v[c] = 64'(packet);

    axi_transmit #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst_v[c]),
      .is_addr    (isaddr_v[c]),
      .data_in    (din),
      .valid_in   (vin_v[c]),
      .ready_out  (rdy_v[c]),
      .packet     (packet),
      .valid_pack (vp_v[c]),
      .pack_ready (prdy_v[c]),
      .done       (done_v[c])
    );

    logic [63:0] pq[$];
    bit          lq[$];
    logic [63:0] wq[$];
    logic [63:0] asm_w;
    int          asm_i;
    bit          done_exp;
    bit          armed = 1'b0;

    function automatic logic [63:0] conv(logic [63:0] d, logic a);
      logic [63:0] id;
      id = d & DMASK;
      if (a !== 1'b1) return id;
      if (id > 64'(`ABS_ID_CEILING)) id = 64'(`ABS_ID_CEILING);
      return `ID2ADDR(id) & DMASK;
    endfunction

    // Reference model: a queue of expected packets, plus a receiver that
    // reassembles the DUT's packets and compares each finished word.
    always @(posedge clk) begin : model
      int          sz;
      bit          rdy_e;
      logic [63:0] w;
      sz    = pq.size();
      rdy_e = (sz == 0) || (sz == 1 && prdy_v[c] === 1'b1);
      if (rst_v[c] === 1'b1) begin
        pq.delete();
        lq.delete();
        wq.delete();
        asm_w    = '0;
        asm_i    = 0;
        done_exp = 1'b0;
        armed    = 1'b1;
      end else if (armed) begin
        done_exp = 1'b0;
        if (sz > 0 && prdy_v[c] === 1'b1) begin
          asm_w = asm_w | ((pkt_v[c] & BMASK) << (asm_i * BW));
          asm_i++;
          if (lq[0]) begin
            chk("reassembled word", c, asm_w, wq[0]);
            void'(wq.pop_front());
            asm_w    = '0;
            asm_i    = 0;
            done_exp = 1'b1;
          end
          void'(pq.pop_front());
          void'(lq.pop_front());
        end
        if (vin_v[c] === 1'b1 && rdy_e) begin
          w = conv(din_v[c], isaddr_v[c]);
          wq.push_back(w);
          for (int i = 0; i < NP; i++) begin
            pq.push_back((w >> (i * BW)) & BMASK);
            lq.push_back(i == NP - 1);
          end
        end
      end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
      int          sz;
      logic [63:0] exp_pkt;
      if (armed) begin
        sz      = pq.size();
        exp_pkt = '0;
        if (sz > 0) exp_pkt = pq[0];
        chk("valid_pack", c, 64'(vp_v[c]), 64'(sz > 0));
        chk("packet", c, pkt_v[c], exp_pkt);
        chk("done", c, 64'(done_v[c]), 64'(done_exp));
        chk("ready_out", c, 64'(rdy_v[c]),
            64'((sz == 0) || (sz == 1 && prdy_v[c] === 1'b1)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int c, logic v, logic [63:0] d, logic a);
    vin_v[c]    = v;
    din_v[c]    = d;
    isaddr_v[c] = a;
  endtask

  task automatic directed_c0();
    logic [63:0] ids [4];
    logic        adr [4];
    logic [63:0] exp [4];
    ids = '{64'd3, 64'd1001, 64'd1000, 64'd3};
    adr = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp = '{64'h1018, 64'h2F40, 64'h2F40, 64'h3};
    @(negedge clk);
    chk("reset valid_pack", 0, 64'(vp_v[0]), 64'd0);
    chk("reset packet", 0, pkt_v[0], 64'd0);
    chk("reset done", 0, 64'(done_v[0]), 64'd0);
    chk("reset ready_out", 0, 64'(rdy_v[0]), 64'd1);
    tick();
    prdy_v[0] = 1'b1;
    drive(0, 1'b1, 64'hABCD, 1'b0);
    @(negedge clk);
    chk("idle ready_out", 0, 64'(rdy_v[0]), 64'd1);
    tick();
    drive(0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("single packet", 0, pkt_v[0], 64'h0000ABCD);
    chk("single valid_pack", 0, 64'(vp_v[0]), 64'd1);
    chk("single ready_out", 0, 64'(rdy_v[0]), 64'd1);
    tick();
    @(negedge clk);
    chk("single done", 0, 64'(done_v[0]), 64'd1);
    chk("single idle valid", 0, 64'(vp_v[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(0, 1'b1, ids[i], adr[i]);
      tick();
      drive(0, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      chk("addr conversion", 0, pkt_v[0], exp[i]);
    end
    repeat (3) tick();
  endtask

  task automatic directed_c1();
    prdy_v[1] = 1'b1;
    tick();
    drive(1, 1'b1, 64'h1234_5678_9ABC, 1'b0);
    tick();
    drive(1, 1'b1, 64'h0F0E_0D0C_0B0A, 1'b0);
    @(negedge clk);
    chk("48/16 pkt0", 1, pkt_v[1], 64'h9ABC);
    chk("48/16 busy ready", 1, 64'(rdy_v[1]), 64'd0);
    tick();
    @(negedge clk);
    chk("48/16 pkt1", 1, pkt_v[1], 64'h5678);
    tick();
    @(negedge clk);
    chk("48/16 pkt2", 1, pkt_v[1], 64'h1234);
    chk("48/16 overlap ready", 1, 64'(rdy_v[1]), 64'd1);
    tick();
    drive(1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("b2b pkt0", 1, pkt_v[1], 64'h0B0A);
    chk("b2b done", 1, 64'(done_v[1]), 64'd1);
    chk("b2b valid", 1, 64'(vp_v[1]), 64'd1);
    tick();
    @(negedge clk);
    chk("b2b pkt1", 1, pkt_v[1], 64'h0D0C);
    tick();
    @(negedge clk);
    chk("b2b pkt2", 1, pkt_v[1], 64'h0F0E);
    tick();
    @(negedge clk);
    chk("b2b final done", 1, 64'(done_v[1]), 64'd1);
    chk("b2b final idle", 1, 64'(vp_v[1]), 64'd0);
    tick();
    drive(1, 1'b1, 64'h1111_2222_3333, 1'b0);
    tick();
    drive(1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("pre-reset pkt0", 1, pkt_v[1], 64'h3333);
    tick();
    rst_v[1] = 1'b1;
    @(negedge clk);
    chk("pre-reset pkt1", 1, pkt_v[1], 64'h2222);
    tick();
    rst_v[1] = 1'b0;
    drive(1, 1'b1, 64'h1, 1'b0);
    @(negedge clk);
    chk("mid reset valid", 1, 64'(vp_v[1]), 64'd0);
    chk("mid reset done", 1, 64'(done_v[1]), 64'd0);
    chk("mid reset ready", 1, 64'(rdy_v[1]), 64'd1);
    tick();
    drive(1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("post-reset pkt0", 1, pkt_v[1], 64'h0001);
    chk("post-reset no done", 1, 64'(done_v[1]), 64'd0);
    tick();
    @(negedge clk);
    chk("post-reset pkt1", 1, pkt_v[1], 64'h0000);
    chk("post-reset valid1", 1, 64'(vp_v[1]), 64'd1);
    tick();
    @(negedge clk);
    chk("post-reset pkt2", 1, pkt_v[1], 64'h0000);
    tick();
    @(negedge clk);
    chk("post-reset done", 1, 64'(done_v[1]), 64'd1);
    repeat (2) tick();
  endtask

  task automatic directed_c2();
    prdy_v[2] = 1'b1;
    tick();
    drive(2, 1'b1, 64'hABCDE, 1'b0);
    tick();
    drive(2, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("20/8 pkt0", 2, pkt_v[2], 64'hDE);
    tick();
    prdy_v[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall packet", 2, pkt_v[2], 64'hBC);
      chk("stall valid", 2, 64'(vp_v[2]), 64'd1);
      chk("stall ready", 2, 64'(rdy_v[2]), 64'd0);
      tick();
    end
    prdy_v[2] = 1'b1;
    @(negedge clk);
    chk("stall release packet", 2, pkt_v[2], 64'hBC);
    tick();
    @(negedge clk);
    chk("padded last packet", 2, pkt_v[2], 64'h0A);
    chk("padded last ready", 2, 64'(rdy_v[2]), 64'd1);
    tick();
    @(negedge clk);
    chk("20/8 done", 2, 64'(done_v[2]), 64'd1);
    repeat (2) tick();
  endtask

  task automatic run_random(int c, int cycles, bit stalls);
    for (int i = 0; i < cycles; i++) begin
      tick();
      rst_v[c]    = stalls && ($urandom_range(0, 299) == 0);
      vin_v[c]    = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      din_v[c]    = {$urandom, $urandom};
      if (stalls && $urandom_range(0, 7) == 0) din_v[c] = 64'($urandom_range(990, 1010));
      isaddr_v[c] = stalls && ($urandom_range(0, 3) == 0);
      prdy_v[c]   = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    tick();
    rst_v[c]  = 1'b0;
    prdy_v[c] = 1'b1;
    drive(c, 1'b0, 64'h0, 1'b0);
    repeat (8) tick();
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      rst_v[c]  = 1'b1;
      prdy_v[c] = 1'b1;
      drive(c, 1'b0, 64'h0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) rst_v[c] = 1'b0;
    directed_c0();
    directed_c1();
    directed_c2();
    for (int c = 0; c < 3; c++) run_random(c, 1500, 1'b1);
    run_random(1, 3000, 1'b0);
    run_random(0, 1000, 1'b0);
    run_random(2, 1500, 1'b0);
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_transmit.md
Name: axi_transmit

Overview:
- Serializing transmitter for the PS↔PL word bus.
- Accepts one DATA_WIDTH word per handshake and emits it as BUS_WIDTH packets, least-significant chunk first, with valid/ready flow control.
- Optionally converts an internal memory ID to its absolute bus address (mem_layout_pkg macros) before sending.
- Sits on the transmit side of the bus, so a word sent here reassembles bit-exactly at the far-end receiver.

Parameters:
- BUS_WIDTH, 32, width of one bus packet in bits.
- DATA_WIDTH, 16, width of one transmitted word in bits.
- NUM_PACKS (derived, localparam), ceil(DATA_WIDTH/BUS_WIDTH), minimum 1; packets per word.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- is_addr  input  1  sampled at word accept; 1 = data_in is a memory ID to convert to an address
- data_in  input  DATA_WIDTH  word to transmit
- valid_in  input  1  data_in valid
- ready_out  output  1  transmitter can accept a word this cycle
- packet  output  BUS_WIDTH  current bus packet
- valid_pack  output  1  packet valid
- pack_ready  input  1  downstream accepts packet this cycle
- done  output  1  one-cycle pulse after the last packet of a word is accepted

Behaviour:
- Reset: rst synchronous, active-high, on clk. After reset: state IDLE, valid_pack=0, packet=0, done=0, shift register=0, pack_idx=0, ready_out=1.
- States:
  - IDLE: ready_out=1, valid_pack=0, packet=0.
  - SEND: valid_pack=1, packet = shift_reg[BUS_WIDTH-1:0].
- Word accept (valid_in && ready_out, rising clk):
  - Latch word w into shift_reg, zero-extended to NUM_PACKS*BUS_WIDTH.
  - pack_idx=0; go to SEND. First packet is valid on the next cycle, giving 1-cycle latency from accept to valid_pack.
- Address conversion when is_addr=1 at accept:
  - If data_in <= `ABS_ID_CEILING: w = `ID2ADDR(data_in).
  - Otherwise: w = `ID2ADDR(`ABS_ID_CEILING)`.
  - Result is truncated to DATA_WIDTH.
  - is_addr=0: w = data_in.
- Packet handshake (SEND && pack_ready):
  - Packet is consumed; shift_reg shifts right by BUS_WIDTH, zero-filled; pack_idx increments.
  - If pack_idx == NUM_PACKS-1, that was the last packet: done=1 next cycle, state → IDLE.
- Backpressure: while valid_pack=1 and pack_ready=0, packet and valid_pack hold stable. No packet is dropped or repeated.
- Back-to-back words:
  - ready_out = IDLE || (SEND && last packet && pack_ready). This is a combinational path from pack_ready.
  - If a new word is accepted in the same cycle as the last-packet handshake, state stays SEND with the new word loaded, and done still pulses.
  - Sustained throughput is one word per NUM_PACKS cycles.
- Width cases:
  - BUS_WIDTH >= DATA_WIDTH: single packet, upper BUS_WIDTH-DATA_WIDTH bits zero.
  - DATA_WIDTH not a multiple of BUS_WIDTH: final packet zero-padded in its MSBs.
- Inputs ignored when ready_out=0: valid_in, data_in and is_addr.
- Reset mid-transfer: the word in flight is discarded. valid_pack=0 on the cycle after rst is sampled; no done pulse.
- pack_idx width is $clog2(NUM_PACKS)+1. It never wraps inside a word.

Test Plan:
- Defaults (BUS=32, DATA=16), pack_ready=1, send 0xABCD with is_addr=0 → one packet 0x0000ABCD one cycle after accept; done pulses the following cycle; ready_out=1 throughout.
- DATA_WIDTH=48, BUS_WIDTH=16, send 0x123456789ABC with pack_ready=1 → packets 0x9ABC, 0x5678, 0x1234 on consecutive cycles; a second word presented continuously is accepted on the cycle 0x1234 is accepted, with no idle gap.
- DATA_WIDTH=20, BUS_WIDTH=8, send 0xABCDE → packets 0xDE, 0xBC, 0x0A. Hold pack_ready=0 for 3 cycles during 0xBC → packet stays 0xBC with valid_pack=1; ready_out=0.
- is_addr=1, data_in=3 → packet = `ID2ADDR(3)`. data_in=`ABS_ID_CEILING+1` → packet = `ID2ADDR(`ABS_ID_CEILING)`. is_addr=0, data_in=3 → packet = 3.
- DATA=48/BUS=16, assert rst after the first packet is accepted → valid_pack=0 next cycle, no done pulse, ready_out=1. A new word 0x000000000001 then transmits cleanly as 0x0001, 0x0000, 0x0000.
- Loopback: feed packet/valid_pack into the matching receiver, with random pack_ready stalls disabled, 1000 random words → every reassembled word equals the sent word.
